// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if
//   Groups the signals between the PLL reset sequencer and its surroundings.
//   master: the sequencer. It takes the PLL lock status and relock request,
//           and drives the PLL reset, core reset and status outputs.
//   slave : the environment, i.e. the PLL wrapper, reset tree and supervisor.
//   Signals:
//     locked_in     PLL locked indication, asynchronous to refclk
//     force_relock  single-cycle request to restart the sequence
//     pll_rst       PLL reset, active high
//     sys_rst_n     core reset, active low
//     ready         high while the core is running on a stable lock
//     fail          high once all lock attempts are exhausted
//     retry_cnt     retries consumed in the current sequence
interface pll_reset_seq_if;
    logic       locked_in;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;

    modport master (
        input  locked_in,
        input  force_relock,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fail,
        output retry_cnt
    );

    modport slave (
        output locked_in,
        output force_relock,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Board PLL reset sequencer. It pulses the PLL reset, waits for a lock and
//   requires that lock to hold for LOCK_STABLE cycles before it releases the
//   core reset. A lock timeout triggers another attempt. Once MAX_RETRY
//   retries have been used up, the sequencer parks in FAIL with the PLL held
//   in reset. Losing the lock while running restarts the whole sequence.
//   Ports:
//     refclk  reference clock; all logic runs on its rising edge
//     rst_n   asynchronous active-low reset
//     bus     pll_reset_seq_if.master (lock in, relock request, resets, status)
module pll_reset_seq #(
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
    pll_reset_seq_if.master   bus
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic             sync1_reg, lock_s_reg;
    logic             pll_rst_reg, sys_rst_n_reg, ready_reg, fail_reg;

    // locked_in is asynchronous to refclk, so it is brought in through two flops.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= bus.locked_in;
            lock_s_reg <= sync1_reg;
        end
    end

    // Next-state logic. Every terminal compare clears cnt, so the counter
    // can never wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        if (bus.force_relock) begin
            // A relock request overrides any transition due on this cycle.
            state_next = RESET_PLL;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s_reg) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = FAIL;
                        end else begin
                            state_next = RESET_PLL;
                            retry_next = retry_reg + 4'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                STABLE: begin
                    // A lock drop here is treated as a glitch. It is not
                    // counted as a retry.
                    if (!lock_s_reg) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    // Losing the lock while running starts a fresh sequence.
                    if (!lock_s_reg) begin
                        state_next = RESET_PLL;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                FAIL: begin
                    state_next = FAIL;
                end
                default: begin
                    state_next = RESET_PLL;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    // State register. The outputs are decoded from state_next, so each output
    // changes on the same edge that enters the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_PLL;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAIL);
            sys_rst_n_reg <= (state_next == RUN);
            ready_reg     <= (state_next == RUN);
            fail_reg      <= (state_next == FAIL);
        end
    end

    assign bus.pll_rst   = pll_rst_reg;
    assign bus.sys_rst_n = sys_rst_n_reg;
    assign bus.ready     = ready_reg;
    assign bus.fail      = fail_reg;
    assign bus.retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Directed checks of pll_reset_seq with RST_HOLD_CYC=4, LOCK_TIMEOUT=20,
//   LOCK_STABLE=8 and MAX_RETRY=2. Each check compares an output vector
//   {pll_rst, sys_rst_n, ready, fail, retry_cnt[3:0]} against a value worked
//   out by hand. Outputs are sampled 1 time unit after the rising edge.
module tb_pll_reset_seq;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 refclk = ~refclk;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .RST_HOLD_CYC (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (2),
        .CNT_W        (16)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    wire [7:0] obs = {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail, bus.retry_cnt};

    function automatic logic [7:0] mk(input logic p, input logic s, input logic r,
                                      input logic f, input int rt);
        return {p, s, r, f, 4'(rt)};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // 1. Reset values, then a 4-edge pll_rst pulse after rst_n is released.
    task automatic test_reset();
        logic [7:0] exp_v;
        rst_n = 1'b0;
        bus.locked_in = 1'b0;
        bus.force_relock = 1'b0;
        #12;
        exp_v = mk(1, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_values: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = mk(i < 4, 0, 0, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_reset done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 2. A lock raised before edge e releases the core at edge e+10.
    task automatic test_lock();
        logic [7:0] exp_v;
        bus.locked_in = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_v = mk(0, i == 11, i == 11, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL lock_release[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_lock done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 5. Losing the lock in RUN drops sys_rst_n at e+2, then a 4-cycle PLL reset follows.
    task automatic test_lock_loss();
        logic [7:0] exp_v;
        bus.locked_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_v = mk(i >= 3 && i <= 6, i < 3, i < 3, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL lock_loss[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_lock_loss done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 3. A lock glitch in STABLE at cnt=5 delays the release until 10 edges after the restore.
    task automatic test_glitch();
        logic [7:0] exp_v;
        bus.locked_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_v = mk(0, 0, 0, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL glitch_pre[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        bus.locked_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = mk(0, 0, 0, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL glitch_drop[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        bus.locked_in = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_v = mk(0, i == 11, i == 11, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL glitch_restore[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_glitch done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 4. With no lock: an initial attempt plus 2 retries, then FAIL is held.
    task automatic test_timeout_fail();
        logic [7:0] exp_v;
        bus.locked_in = 1'b0;
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        exp_v = mk(1, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL relock_from_run: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        for (int a = 0; a <= 2; a++) begin
            for (int i = 1; i <= 24; i++) begin
                tick();
                if (i <= 3)      exp_v = mk(1, 0, 0, 0, a);
                else if (i < 24) exp_v = mk(0, 0, 0, 0, a);
                else if (a < 2)  exp_v = mk(1, 0, 0, 0, a + 1);
                else             exp_v = mk(1, 0, 0, 1, 2);
                total_cnt++;
                if (obs !== exp_v) $display("FAIL attempt%0d[%0d]: got %b expected %b", a, i, obs, exp_v);
                else pass_cnt++;
            end
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_v = mk(1, 0, 0, 1, 2);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL fail_hold[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_timeout_fail done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 6a. force_relock leaves FAIL and restarts the hold count while in RESET_PLL.
    task automatic test_force_relock();
        logic [7:0] exp_v;
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        exp_v = mk(1, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL relock_from_fail: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        tick();
        tick();
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = mk(i < 4, 0, 0, 0, 0);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL relock_restart_hold[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        $display("test_force_relock done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 6b. force_relock on the same edge as a WAIT_LOCK timeout wins and clears retry_cnt.
    task automatic test_force_on_timeout();
        logic [7:0] exp_v;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_v = (i < 20) ? mk(0, 0, 0, 0, 0) : mk(1, 0, 0, 0, 1);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL first_timeout[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        for (int i = 1; i <= 4; i++) tick();
        for (int i = 1; i <= 19; i++) begin
            tick();
            exp_v = mk(0, 0, 0, 0, 1);
            total_cnt++;
            if (obs !== exp_v) $display("FAIL second_wait[%0d]: got %b expected %b", i, obs, exp_v);
            else pass_cnt++;
        end
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        exp_v = mk(1, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL relock_vs_timeout: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        $display("test_force_on_timeout done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    // 6c. Asserting rst_n mid-STABLE restores the reset values without a clock edge.
    task automatic test_async_reset();
        logic [7:0] exp_v;
        for (int i = 1; i <= 4; i++) tick();
        for (int i = 1; i <= 20; i++) tick();
        for (int i = 1; i <= 4; i++) tick();
        bus.locked_in = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        exp_v = mk(0, 0, 0, 0, 1);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL in_stable: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = mk(1, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL async_reset: got %b expected %b", obs, exp_v);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        $display("test_async_reset done: %0d/%0d", pass_cnt, total_cnt);
    endtask

    initial begin
        bus.locked_in = 1'b0;
        bus.force_relock = 1'b0;
        test_reset();
        test_lock();
        test_lock_loss();
        test_glitch();
        test_timeout_fail();
        test_force_relock();
        test_force_on_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
